// File: rtl/rf_pkg.sv
// Shared widths and FSM state type for the register-file writeback arbiter.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_AGED   = 1'b1
  } arb_state_e;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Pending-destination vector: issue sets a bit, long-latency writeback clears it.
// When both hit the same register in one cycle, the new issue wins.
module rf_scoreboard #(
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_set,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] busy_next;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    busy_next = o_busy;
    if (i_clr) busy_next[i_clr_addr] = 1'b0;
    if (i_set) busy_next[i_set_addr] = 1'b1;
    busy_next[0] = 1'b0;  // x0 is hardwired, never pending
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_busy <= '0;
    else       o_busy <= busy_next;
  end

endmodule : rf_scoreboard

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline (req0) and the
// long-latency unit (req1), with aging so req1 cannot starve, plus a busy scoreboard.
module rf_wb_arbiter #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_wren,
  output logic [31:0]       o_busy
);

  import rf_pkg::*;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  arb_state_e  state;
  logic [3:0]  wait_cnt;
  logic        grant0;
  logic        grant1;
  logic        denied1;

  // Priority flips to req1 only while aged; grants depend on valids and state alone.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ARB_AGED) begin
      grant1 = i_req1_valid;
      grant0 = i_req0_valid && !i_req1_valid;
    end else begin
      grant0 = i_req0_valid;
      grant1 = i_req1_valid && !i_req0_valid;
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;
  assign denied1      = i_req1_valid && !grant1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ARB_NORMAL;
      wait_cnt <= '0;
    end else begin
      if (denied1) begin
        if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        ARB_NORMAL: if (denied1 && wait_cnt == WAIT_LAST) state <= ARB_AGED;
        ARB_AGED:   if (grant1 || !i_req1_valid)          state <= ARB_NORMAL;
        default:                                          state <= ARB_NORMAL;
      endcase
    end
  end

  // Writes to x0 are accepted but never reach the register file; addr/data then hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= 1'b0;
      if (grant0 && i_req0_addr != '0) begin
        o_rd_wren <= 1'b1;
        o_rd_addr <= i_req0_addr;
        o_rd_data <= i_req0_data;
      end else if (grant1 && i_req1_addr != '0) begin
        o_rd_wren <= 1'b1;
        o_rd_addr <= i_req1_addr;
        o_rd_data <= i_req1_data;
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (32)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set      (i_issue_valid),
    .i_set_addr (i_issue_addr),
    .i_clr      (grant1),
    .i_clr_addr (i_req1_addr),
    .o_busy     (o_busy)
  );

endmodule : rf_wb_arbiter
